// File: rtl/mem_rr_arbiter.sv
// Memory arbiter: serves one read or write from NUM_CLIENTS requesters at a time on a single
// memory port, using round-robin or fixed-priority selection, with upstream or fixed-latency completion.
module mem_rr_arbiter #(
  parameter int NUM_CLIENTS           = 8,
  parameter int ADDR_SIZE             = 32,
  parameter int WRITE_DATA_SIZE       = 32,
  parameter int READ_DATA_SIZE        = 512,
  parameter bit HAVE_UPSTREAM_ARBITER = 1'b1,
  parameter int READ_LATENCY          = 1,
  parameter bit PRIORITY_MODE         = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CLIENTS-1:0]                 client_read_en,
  input  logic [NUM_CLIENTS*ADDR_SIZE-1:0]       client_read_addr,
  input  logic [NUM_CLIENTS-1:0]                 client_write_en,
  input  logic [NUM_CLIENTS*ADDR_SIZE-1:0]       client_write_addr,
  input  logic [NUM_CLIENTS*WRITE_DATA_SIZE-1:0] client_write_data,
  input  logic [READ_DATA_SIZE-1:0]              mem_read_data,
  input  logic                                   upstream_write_done,
  input  logic                                   upstream_read_valid,
  output logic [READ_DATA_SIZE-1:0]              client_read_data,
  output logic [NUM_CLIENTS-1:0]                 client_read_valid,
  output logic [NUM_CLIENTS-1:0]                 client_write_done,
  output logic                                   mem_read_en,
  output logic                                   mem_write_en,
  output logic [ADDR_SIZE-1:0]                   mem_read_addr,
  output logic [ADDR_SIZE-1:0]                   mem_write_addr,
  output logic [WRITE_DATA_SIZE-1:0]             mem_write_data,
  output logic                                   busy,
  output logic                                   protocol_err
);

  localparam int CW = $clog2(NUM_CLIENTS);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t                     state;
  logic [CW-1:0]              grant;
  logic [CW-1:0]              last_grant;
  logic [CW-1:0]              pick;
  logic [CW-1:0]              cand;
  logic [2:0]                 lat_cnt;
  logic [NUM_CLIENTS-1:0]     req;
  logic [NUM_CLIENTS-1:0]     grant_oh;
  logic                       up_any;
  int                         rr_idx;

  logic [ADDR_SIZE-1:0]       rd_addr [NUM_CLIENTS];
  logic [ADDR_SIZE-1:0]       wr_addr [NUM_CLIENTS];
  logic [WRITE_DATA_SIZE-1:0] wr_data [NUM_CLIENTS];

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
    assign rd_addr[i] = client_read_addr[i*ADDR_SIZE +: ADDR_SIZE];
    assign wr_addr[i] = client_write_addr[i*ADDR_SIZE +: ADDR_SIZE];
    assign wr_data[i] = client_write_data[i*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
  end

  assign req      = client_read_en | client_write_en;
  assign grant_oh = NUM_CLIENTS'(1) << grant;
  assign up_any   = upstream_read_valid | upstream_write_done;
  assign busy     = (state != IDLE);

  // Scan candidates from lowest to highest priority so the last hit is the winner.
  always_comb begin
    pick   = '0;
    cand   = '0;
    rr_idx = 0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      if (PRIORITY_MODE) rr_idx = k - 1;
      else               rr_idx = (int'(last_grant) + k) % NUM_CLIENTS;
      cand = CW'(rr_idx);
      if (req[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      grant             <= '0;
      last_grant        <= CW'(NUM_CLIENTS - 1);
      lat_cnt           <= '0;
      client_read_data  <= '0;
      client_read_valid <= '0;
      client_write_done <= '0;
      mem_read_en       <= 1'b0;
      mem_write_en      <= 1'b0;
      mem_read_addr     <= '0;
      mem_write_addr    <= '0;
      mem_write_data    <= '0;
      protocol_err      <= 1'b0;
    end else begin
      client_read_valid <= '0;
      client_write_done <= '0;
      protocol_err      <= 1'b0;
      case (state)
        IDLE: begin
          protocol_err <= up_any;
          if (|req) begin
            grant <= pick;
            // A client holding both requests gets its write first; the read waits for a later grant.
            if (client_write_en[pick]) begin
              mem_write_en   <= 1'b1;
              mem_write_addr <= wr_addr[pick];
              mem_write_data <= wr_data[pick];
              state          <= WR_WAIT;
            end else begin
              mem_read_en   <= 1'b1;
              mem_read_addr <= rd_addr[pick];
              lat_cnt       <= 3'(READ_LATENCY);
              state         <= RD_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (HAVE_UPSTREAM_ARBITER) begin
            protocol_err <= upstream_read_valid;
            if (upstream_write_done) begin
              mem_write_en      <= 1'b0;
              client_write_done <= grant_oh;
              state             <= RESP;
            end
          end else begin
            protocol_err      <= up_any;
            mem_write_en      <= 1'b0;
            client_write_done <= grant_oh;
            state             <= RESP;
          end
        end
        RD_WAIT: begin
          if (HAVE_UPSTREAM_ARBITER) begin
            protocol_err <= upstream_write_done;
            if (upstream_read_valid) begin
              mem_read_en       <= 1'b0;
              client_read_data  <= mem_read_data;
              client_read_valid <= grant_oh;
              state             <= RESP;
            end
          end else begin
            // Local memory: enable is a single-cycle strobe, data is taken when the count reaches zero.
            protocol_err <= up_any;
            mem_read_en  <= 1'b0;
            if (lat_cnt == 3'd0) begin
              client_read_data  <= mem_read_data;
              client_read_valid <= grant_oh;
              state             <= RESP;
            end else begin
              lat_cnt <= lat_cnt - 3'd1;
            end
          end
        end
        RESP: begin
          protocol_err <= up_any;
          last_grant   <= grant;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: an upstream round-robin instance and a local fixed-priority instance,
// checked against a transaction-level model of grant order, latency and response routing.
module tb_mem_rr_arbiter;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int WD = 32;
  localparam int RD = 512;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]    rd_en_a, wr_en_a, rd_en_b, wr_en_b;
  logic [N*AW-1:0] rd_addr_a, wr_addr_a, rd_addr_b, wr_addr_b;
  logic [N*WD-1:0] wr_data_a, wr_data_b;
  logic [RD-1:0]   mem_rdata_a, mem_rdata_b, rdata_a, rdata_b;
  logic            up_wd_a, up_rv_a, up_wd_b, up_rv_b;
  logic [N-1:0]    rvalid_a, wdone_a, rvalid_b, wdone_b;
  logic            mre_a, mwe_a, mre_b, mwe_b, busy_a, busy_b, perr_a, perr_b;
  logic [AW-1:0]   mra_a, mwa_a, mra_b, mwa_b;
  logic [WD-1:0]   mwd_a, mwd_b;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NUM_CLIENTS(N), .ADDR_SIZE(AW), .WRITE_DATA_SIZE(WD), .READ_DATA_SIZE(RD),
                   .HAVE_UPSTREAM_ARBITER(1'b1), .READ_LATENCY(1), .PRIORITY_MODE(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .client_read_en(rd_en_a), .client_read_addr(rd_addr_a),
    .client_write_en(wr_en_a), .client_write_addr(wr_addr_a), .client_write_data(wr_data_a),
    .mem_read_data(mem_rdata_a), .upstream_write_done(up_wd_a), .upstream_read_valid(up_rv_a),
    .client_read_data(rdata_a), .client_read_valid(rvalid_a), .client_write_done(wdone_a),
    .mem_read_en(mre_a), .mem_write_en(mwe_a), .mem_read_addr(mra_a), .mem_write_addr(mwa_a),
    .mem_write_data(mwd_a), .busy(busy_a), .protocol_err(perr_a)
  );

  mem_rr_arbiter #(.NUM_CLIENTS(N), .ADDR_SIZE(AW), .WRITE_DATA_SIZE(WD), .READ_DATA_SIZE(RD),
                   .HAVE_UPSTREAM_ARBITER(1'b0), .READ_LATENCY(3), .PRIORITY_MODE(1'b1)) u_fp (
    .clk(clk), .rst(rst),
    .client_read_en(rd_en_b), .client_read_addr(rd_addr_b),
    .client_write_en(wr_en_b), .client_write_addr(wr_addr_b), .client_write_data(wr_data_b),
    .mem_read_data(mem_rdata_b), .upstream_write_done(up_wd_b), .upstream_read_valid(up_rv_b),
    .client_read_data(rdata_b), .client_read_valid(rvalid_b), .client_write_done(wdone_b),
    .mem_read_en(mre_b), .mem_write_en(mwe_b), .mem_read_addr(mra_b), .mem_write_addr(mwa_b),
    .mem_write_data(mwd_b), .busy(busy_b), .protocol_err(perr_b)
  );

  function automatic logic [RD-1:0] rand_wide();
    logic [RD-1:0] v;
    v = '0;
    for (int i = 0; i < RD / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Round-robin rule: first requester after the previous winner, wrapping around.
  function automatic int rr_next(input logic [N-1:0] mask, input int last);
    for (int d = 1; d <= N; d++)
      if (mask[(last + d) % N]) return (last + d) % N;
    return 0;
  endfunction

  task automatic clear_inputs();
    rd_en_a = '0; wr_en_a = '0; rd_en_b = '0; wr_en_b = '0;
    up_wd_a = 1'b0; up_rv_a = 1'b0; up_wd_b = 1'b0; up_rv_b = 1'b0;
    mem_rdata_a = '0; mem_rdata_b = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_read_a(input int i);
    rd_addr_a[i*AW +: AW] = {8'(i), 24'($urandom)};
    rd_en_a[i] = 1'b1;
  endtask

  task automatic set_write_a(input int i);
    wr_addr_a[i*AW +: AW] = {8'(i), 24'($urandom)};
    wr_data_a[i*WD +: WD] = $urandom;
    wr_en_a[i] = 1'b1;
  endtask

  task automatic wait_en_a(output bit ok, output int waited);
    ok = 1'b0; waited = 0;
    while (!ok && waited < 20) begin
      @(negedge clk);
      waited++;
      ok = mre_a | mwe_a;
    end
  endtask

  task automatic wait_en_b(output bit ok, output int waited);
    ok = 1'b0; waited = 0;
    while (!ok && waited < 20) begin
      @(negedge clk);
      waited++;
      ok = mre_b | mwe_b;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rd_en_a = N'($urandom); wr_en_a = N'($urandom); rd_en_b = N'($urandom); wr_en_b = N'($urandom);
      rd_addr_a = {N{$urandom}}; wr_addr_a = {N{$urandom}}; wr_data_a = {N{$urandom}};
      rd_addr_b = {N{$urandom}}; wr_addr_b = {N{$urandom}}; wr_data_b = {N{$urandom}};
      mem_rdata_a = rand_wide(); mem_rdata_b = rand_wide();
      up_wd_a = 1'($urandom); up_rv_a = 1'($urandom); up_wd_b = 1'($urandom); up_rv_b = 1'($urandom);
      @(negedge clk);
    end
    checks++;
    if ({rvalid_a, wdone_a, mre_a, mwe_a, busy_a, perr_a} !== '0) begin
      errs++; $display("FAIL reset_ctrl_a: got %h want 0", {rvalid_a, wdone_a, mre_a, mwe_a, busy_a, perr_a});
    end
    checks++;
    if ({mra_a, mwa_a, mwd_a} !== '0) begin
      errs++; $display("FAIL reset_addr_a: got %h want 0", {mra_a, mwa_a, mwd_a});
    end
    checks++;
    if (rdata_a !== '0) begin errs++; $display("FAIL reset_rdata_a: got %h want 0", rdata_a); end
    checks++;
    if ({rvalid_b, wdone_b, mre_b, mwe_b, busy_b, perr_b} !== '0) begin
      errs++; $display("FAIL reset_ctrl_b: got %h want 0", {rvalid_b, wdone_b, mre_b, mwe_b, busy_b, perr_b});
    end
    checks++;
    if ({mra_b, mwa_b, mwd_b, rdata_b} !== '0) begin
      errs++; $display("FAIL reset_data_b: got nonzero want 0");
    end
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    wr_addr_a[3*AW +: AW] = 32'h0000_5000;
    wr_data_a[3*WD +: WD] = 32'hDEAD_BEEF;
    wr_en_a[3] = 1'b1;
    @(negedge clk);
    checks++;
    if ({mwe_a, mre_a, busy_a} !== 3'b101) begin
      errs++; $display("FAIL reset_first_en: got we/re/busy=%b want 101", {mwe_a, mre_a, busy_a});
    end
    checks++;
    if (mwa_a !== 32'h0000_5000 || mwd_a !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL reset_first_wr: got addr=%h data=%h want 00005000 deadbeef", mwa_a, mwd_a);
    end
    up_wd_a = 1'b1;
    @(negedge clk);
    up_wd_a = 1'b0; wr_en_a[3] = 1'b0;
    checks++;
    if (wdone_a !== 8'h08 || mwe_a !== 1'b0) begin
      errs++; $display("FAIL reset_first_done: got done=%h we=%b want 08 0", wdone_a, mwe_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin errs++; $display("FAIL reset_first_idle: got busy=%b want 0", busy_a); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  mask;
    logic [RD-1:0] d;
    int last, exp, n;
    bit ok;
    do_reset();
    last = N - 1;
    mask = 8'b0010_0101;
    set_read_a(0); set_read_a(2); set_read_a(5);
    for (int t = 0; t < 6; t++) begin
      exp = rr_next(mask, last);
      wait_en_a(ok, n);
      checks++;
      if (!ok || n != 1 || mre_a !== 1'b1 || mra_a !== rd_addr_a[exp*AW +: AW]) begin
        errs++; $display("FAIL rr_grant t=%0d: got ok=%b wait=%0d addr=%h want client %0d addr=%h after 1",
                         t, ok, n, mra_a, exp, rd_addr_a[exp*AW +: AW]);
      end
      @(negedge clk);
      checks++;
      if (mre_a !== 1'b1 || mra_a !== rd_addr_a[exp*AW +: AW]) begin
        errs++; $display("FAIL rr_hold t=%0d: got en=%b addr=%h want held", t, mre_a, mra_a);
      end
      @(negedge clk);
      d = rand_wide();
      mem_rdata_a = d; up_rv_a = 1'b1;
      @(negedge clk);
      up_rv_a = 1'b0;
      checks++;
      if (rvalid_a !== 8'(1 << exp) || rdata_a !== d || mre_a !== 1'b0) begin
        errs++; $display("FAIL rr_valid t=%0d: got valid=%h en=%b want valid=%h en=0", t, rvalid_a, mre_a, 8'(1 << exp));
      end
      @(negedge clk);
      checks++;
      if (rvalid_a !== '0) begin errs++; $display("FAIL rr_pulse_len t=%0d: got valid=%h want 00", t, rvalid_a); end
      last = exp;
    end
    rd_en_a = '0;
    repeat (6) @(negedge clk);
    up_rv_a = 1'b1;
    @(negedge clk);
    up_rv_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rw_same_client();
    int n;
    bit ok;
    do_reset();
    set_read_a(4); set_write_a(4);
    wait_en_a(ok, n);
    checks++;
    if (!ok || mwe_a !== 1'b1 || mre_a !== 1'b0 || mwa_a !== wr_addr_a[4*AW +: AW] || mwd_a !== wr_data_a[4*WD +: WD]) begin
      errs++; $display("FAIL rw_write_first: got we=%b re=%b addr=%h data=%h want write of client 4", mwe_a, mre_a, mwa_a, mwd_a);
    end
    up_wd_a = 1'b1;
    @(negedge clk);
    up_wd_a = 1'b0; wr_en_a[4] = 1'b0;
    checks++;
    if (wdone_a !== 8'h10 || rvalid_a !== '0) begin
      errs++; $display("FAIL rw_write_done: got done=%h valid=%h want 10 00", wdone_a, rvalid_a);
    end
    wait_en_a(ok, n);
    checks++;
    if (!ok || mre_a !== 1'b1 || mra_a !== rd_addr_a[4*AW +: AW]) begin
      errs++; $display("FAIL rw_read_grant: got re=%b addr=%h want 1 %h", mre_a, mra_a, rd_addr_a[4*AW +: AW]);
    end
    up_wd_a = 1'b1;
    @(negedge clk);
    up_wd_a = 1'b0;
    checks++;
    if (perr_a !== 1'b1 || mre_a !== 1'b1 || wdone_a !== '0) begin
      errs++; $display("FAIL rw_wrong_type: got err=%b re=%b done=%h want 1 1 00", perr_a, mre_a, wdone_a);
    end
    mem_rdata_a = {64{8'hA5}}; up_rv_a = 1'b1;
    @(negedge clk);
    up_rv_a = 1'b0; rd_en_a[4] = 1'b0;
    mem_rdata_a = rand_wide();
    checks++;
    if (rvalid_a !== 8'h10 || rdata_a !== {64{8'hA5}}) begin
      errs++; $display("FAIL rw_read_valid: got valid=%h data=%h want 10 a5..a5", rvalid_a, rdata_a);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rdata_a !== {64{8'hA5}} || perr_a !== 1'b0) begin
      errs++; $display("FAIL rw_data_hold: got data=%h err=%b want a5..a5 0", rdata_a, perr_a);
    end
  endtask

  task automatic test_stray_and_reset();
    int n;
    bit ok, seen;
    do_reset();
    up_rv_a = 1'b1;
    @(negedge clk);
    up_rv_a = 1'b0;
    checks++;
    if (perr_a !== 1'b1 || rvalid_a !== '0) begin
      errs++; $display("FAIL stray_idle: got err=%b valid=%h want 1 00", perr_a, rvalid_a);
    end
    @(negedge clk);
    checks++;
    if (perr_a !== 1'b0) begin errs++; $display("FAIL stray_err_len: got err=%b want 0", perr_a); end
    set_read_a(0);
    wait_en_a(ok, n);
    checks++;
    if (!ok || mre_a !== 1'b1) begin errs++; $display("FAIL stray_grant: got re=%b want 1", mre_a); end
    rd_en_a[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || mre_a !== 1'b0) begin
      errs++; $display("FAIL midwait_reset: got busy=%b re=%b want 0 0", busy_a, mre_a);
    end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= |rvalid_a; end
    checks++;
    if (seen !== 1'b0) begin errs++; $display("FAIL midwait_no_valid: got valid pulse want none"); end
    up_rv_a = 1'b1;
    @(negedge clk);
    up_rv_a = 1'b0;
    checks++;
    if (perr_a !== 1'b1 || rvalid_a !== '0) begin
      errs++; $display("FAIL late_response: got err=%b valid=%h want 1 00", perr_a, rvalid_a);
    end
  endtask

  task automatic test_fixed_priority();
    logic [RD-1:0] good;
    int exp, n;
    bit ok;
    do_reset();
    rd_addr_b[1*AW +: AW] = {8'd1, 24'($urandom)}; rd_en_b[1] = 1'b1;
    rd_addr_b[6*AW +: AW] = {8'd6, 24'($urandom)}; rd_en_b[6] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp = (t < 3) ? 1 : 6;
      wait_en_b(ok, n);
      checks++;
      if (!ok || mre_b !== 1'b1 || mra_b !== rd_addr_b[exp*AW +: AW]) begin
        errs++; $display("FAIL fp_grant t=%0d: got addr=%h want client %0d", t, mra_b, exp);
      end
      good = rand_wide();
      for (int k = 0; k <= 3; k++) begin
        mem_rdata_b = (k == 3) ? good : rand_wide();
        @(negedge clk);
        if (k == 0) begin
          checks++;
          if (mre_b !== 1'b0) begin errs++; $display("FAIL local_en_len t=%0d: got re=%b want 0", t, mre_b); end
        end
        if (k < 3) begin
          checks++;
          if (rvalid_b !== '0) begin errs++; $display("FAIL local_early k=%0d: got valid=%h want 00", k, rvalid_b); end
        end
      end
      checks++;
      if (rvalid_b !== 8'(1 << exp) || rdata_b !== good) begin
        errs++; $display("FAIL local_latency t=%0d: got valid=%h data_ok=%b want %h 1", t, rvalid_b, rdata_b === good, 8'(1 << exp));
      end
      if (t == 2) rd_en_b[1] = 1'b0;
      if (t == 3) rd_en_b[6] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_local_write();
    int n;
    bit ok;
    wr_addr_b[2*AW +: AW] = 32'h0002_0000 | 32'($urandom_range(0, 255));
    wr_data_b[2*WD +: WD] = $urandom;
    wr_addr_b[3*AW +: AW] = 32'h0003_0000 | 32'($urandom_range(0, 255));
    wr_data_b[3*WD +: WD] = $urandom;
    wr_en_b[2] = 1'b1; wr_en_b[3] = 1'b1;
    wait_en_b(ok, n);
    checks++;
    if (!ok || mwe_b !== 1'b1 || mwa_b !== wr_addr_b[2*AW +: AW] || mwd_b !== wr_data_b[2*WD +: WD]) begin
      errs++; $display("FAIL lw_grant: got we=%b addr=%h data=%h want client 2", mwe_b, mwa_b, mwd_b);
    end
    @(negedge clk);
    wr_en_b[2] = 1'b0;
    checks++;
    if (mwe_b !== 1'b0 || wdone_b !== 8'h04) begin
      errs++; $display("FAIL lw_done: got we=%b done=%h want 0 04", mwe_b, wdone_b);
    end
    @(negedge clk);
    checks++;
    if (mwe_b !== 1'b0 || wdone_b !== '0) begin
      errs++; $display("FAIL lw_gap: got we=%b done=%h want 0 00", mwe_b, wdone_b);
    end
    @(negedge clk);
    checks++;
    if (mwe_b !== 1'b1 || mwa_b !== wr_addr_b[3*AW +: AW]) begin
      errs++; $display("FAIL lw_back_to_back: got we=%b addr=%h want 1 %h", mwe_b, mwa_b, wr_addr_b[3*AW +: AW]);
    end
    @(negedge clk);
    wr_en_b[3] = 1'b0;
    checks++;
    if (wdone_b !== 8'h08) begin errs++; $display("FAIL lw_done2: got done=%h want 08", wdone_b); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0]  prd, pwr;
    logic [RD-1:0] d;
    int last, exp, n, dly;
    bit ok, isw;
    do_reset();
    last = N - 1; prd = '0; pwr = '0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 0) begin set_read_a(i); prd[i] = 1'b1; end
      if ($urandom_range(0, 2) == 0) begin set_write_a(i); pwr[i] = 1'b1; end
    end
    for (int t = 0; t < 24; t++) begin
      if ((prd | pwr) == '0) begin set_read_a(t % N); prd[t % N] = 1'b1; end
      exp = rr_next(prd | pwr, last);
      isw = pwr[exp];
      wait_en_a(ok, n);
      checks++;
      if (!ok || mwe_a !== isw || mre_a !== !isw) begin
        errs++; $display("FAIL rand_type t=%0d: got re=%b we=%b want write=%b", t, mre_a, mwe_a, isw);
      end
      checks++;
      if (isw ? (mwa_a !== wr_addr_a[exp*AW +: AW] || mwd_a !== wr_data_a[exp*WD +: WD])
              : (mra_a !== rd_addr_a[exp*AW +: AW])) begin
        errs++; $display("FAIL rand_addr t=%0d: got ra=%h wa=%h wd=%h want client %0d", t, mra_a, mwa_a, mwd_a, exp);
      end
      dly = $urandom_range(0, 3);
      repeat (dly) @(negedge clk);
      d = rand_wide();
      if (isw) up_wd_a = 1'b1;
      else begin up_rv_a = 1'b1; mem_rdata_a = d; end
      @(negedge clk);
      up_wd_a = 1'b0; up_rv_a = 1'b0;
      checks++;
      if (isw ? (wdone_a !== 8'(1 << exp) || rvalid_a !== '0)
              : (rvalid_a !== 8'(1 << exp) || wdone_a !== '0 || rdata_a !== d)) begin
        errs++; $display("FAIL rand_resp t=%0d: got done=%h valid=%h want client %0d write=%b", t, wdone_a, rvalid_a, exp, isw);
      end
      if (isw) begin pwr[exp] = 1'b0; wr_en_a[exp] = 1'b0; end
      else     begin prd[exp] = 1'b0; rd_en_a[exp] = 1'b0; end
      last = exp;
      for (int i = 0; i < N; i++) begin
        if (!prd[i] && $urandom_range(0, 3) == 0) begin set_read_a(i); prd[i] = 1'b1; end
        if (!pwr[i] && $urandom_range(0, 5) == 0) begin set_write_a(i); pwr[i] = 1'b1; end
      end
    end
    clear_inputs();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rw_same_client();
    test_stray_and_reset();
    test_fixed_priority();
    test_local_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Parametrised memory arbiter that sits between a bank of NUM_CLIENTS accelerator cores and a single Data Memory port, or an upstream arbiter, in the accelerator cluster. It replaces the fixed eight-client arbiter with the following:

- selectable round-robin or fixed-priority grant;
- an explicit one-outstanding-transaction state machine;
- a configurable local read latency when no upstream arbiter exists;
- a protocol-error flag for stray upstream responses.

Clients issue level requests and hold them until they receive a one-cycle done/valid pulse.

## Interface
Parameters:
- NUM_CLIENTS, 8, number of requesting clients (2..16)
- ADDR_SIZE, 32, address width per client and to memory
- WRITE_DATA_SIZE, 32, write data width
- READ_DATA_SIZE, 512, read data width
- HAVE_UPSTREAM_ARBITER, 1, 1 = wait for upstream_*; 0 = local fixed-latency memory
- READ_LATENCY, 1, cycles from mem_read_en to mem_read_data valid when HAVE_UPSTREAM_ARBITER=0 (1..7)
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- client_read_en  in  NUM_CLIENTS  per-client read request (level)
- client_read_addr  in  NUM_CLIENTS*ADDR_SIZE  flattened; client i at [i*ADDR_SIZE +: ADDR_SIZE]
- client_write_en  in  NUM_CLIENTS  per-client write request (level)
- client_write_addr  in  NUM_CLIENTS*ADDR_SIZE  flattened as above
- client_write_data  in  NUM_CLIENTS*WRITE_DATA_SIZE  flattened, same indexing rule
- mem_read_data  in  READ_DATA_SIZE  memory read data
- upstream_write_done  in  1  upstream accepted the write (pulse)
- upstream_read_valid  in  1  mem_read_data valid (pulse)
- client_read_data  out  READ_DATA_SIZE  registered read data, broadcast to all clients
- client_read_valid  out  NUM_CLIENTS  one-hot, one-cycle pulse
- client_write_done  out  NUM_CLIENTS  one-hot, one-cycle pulse
- mem_read_en, mem_write_en  out  1  memory requests
- mem_read_addr, mem_write_addr  out  ADDR_SIZE  registered address
- mem_write_data  out  WRITE_DATA_SIZE  registered data
- busy  out  1  state != IDLE
- protocol_err  out  1  one-cycle pulse on an upstream response in a state not expecting it

## Operation
- **Request.** req[i] = client_read_en[i] | client_write_en[i].
  - If a client asserts both, its write is served first.
  - Its read is served on a later grant.
- **Grant selection, IDLE only.**
  - PRIORITY_MODE=0: the first requester searching from last_grant+1 upward, wrapping at NUM_CLIENTS.
  - PRIORITY_MODE=1: the lowest-index requester.
  - last_grant resets to NUM_CLIENTS-1, so client 0 wins first.
- **States:** IDLE, RD_WAIT, WR_WAIT, RESP.
- **IDLE, req != 0:**
  - latch grant index, address and (for a write) data into output registers;
  - set mem_*_en;
  - go to RD_WAIT or WR_WAIT.
- **RD_WAIT / WR_WAIT with HAVE_UPSTREAM_ARBITER=1:**
  - hold mem_*_en, address and data stable until the matching upstream pulse;
  - on that pulse: clear en, capture mem_read_data (reads), go to RESP.
- **RD_WAIT / WR_WAIT with HAVE_UPSTREAM_ARBITER=0:**
  - mem_*_en is high for exactly one cycle;
  - writes complete immediately;
  - reads load a 3-bit counter with READ_LATENCY and capture mem_read_data when it expires;
  - then go to RESP.
- **RESP:**
  - pulse client_read_valid[g] or client_write_done[g] for one cycle;
  - update last_grant=g;
  - next state IDLE.
  - RESP blocks re-grant while the client drops its request.
- **Stray responses.** An upstream pulse in IDLE, in RESP, or of the wrong type in a WAIT state is ignored and pulses protocol_err.
- **Data stability.** client_read_data holds its last captured value until the next read capture.
- **Reset values:**
  - all outputs 0;
  - state IDLE;
  - last_grant = NUM_CLIENTS-1.
- **Reset mid-transaction** abandons the transaction: no done/valid is emitted, and a late upstream response afterwards raises protocol_err.

## Timing
- Request seen in IDLE at cycle c → mem_*_en high from c+1.
- Upstream mode: response at cycle t (t ≥ c+1) → mem_*_en low at t+1, client pulse at t+1, IDLE at t+2, next grant en at t+3.
- Local write: mem_write_en at c+1 only, client_write_done at c+2.
- Local read: mem_read_en at c+1, data sampled at c+1+READ_LATENCY, client_read_valid and data at c+2+READ_LATENCY.
- Minimum back-to-back service in local write mode is 3 cycles per transaction.
- A request dropped by a client before grant is simply not selected. A request dropped after grant does not cancel the transaction.

## Test plan
- **Reset.** Assert rst 2 cycles with random inputs → all outputs 0, busy=0. Release, client 3 write addr 0x5000 data 0xDEADBEEF → mem_write_en at c+1 with that addr/data.
- **Round-robin fairness.** NUM_CLIENTS=8, clients 0, 2, 5 hold reads, upstream valid 2 cycles after each en → grant order 0, 2, 5, 0, 2, 5; each valid one-hot and one cycle long.
- **Fixed priority.** PRIORITY_MODE=1, clients 1 and 6 both hold requests → client 1 is served repeatedly while it requests; 6 is served only once 1 drops.
- **Read+write same client.** Client 4 asserts both → write_done[4] precedes read_valid[4]. Read data 512'hA5…A5 appears on client_read_data with the valid pulse.
- **Local latency.** HAVE_UPSTREAM_ARBITER=0, READ_LATENCY=3 → mem_read_en at c+1, valid at c+5. Write done at c+2.
- **Stray response and reset mid-WAIT.** Pulse upstream_read_valid in IDLE → protocol_err for 1 cycle, no client pulse. Reset during RD_WAIT → no valid emitted. A late response afterwards → protocol_err.
